// File: rtl/uart_pkg.sv
// Shared UART definitions, imported by both the transmitter and the
// 16x-oversampling receiver so that they agree on the frame format.
//
// Contents:
//   OVERSAMPLE   - baud ticks per bit period (16)
//   uart_state_e - FSM state encoding. Three bits give five states plus
//                  spare codes kept free for later use.
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level handshake between the command/ALU side and the UART transmitter.
//
// Signals:
//   tx_start     master -> slave  request to send data_in (i_tx_start)
//   data_in      master -> slave  byte to send (i_data_in)
//   tx_ready     slave -> master  holding register empty (o_tx_ready)
//   tx_done_tick slave -> master  1-cycle pulse at the end of each stop bit (o_tx_done_tick)
//
// Modports:
//   master - the byte producer (ALU result path, or a testbench)
//   slave  - the transmitter
interface uart_tx_if #(
   parameter int DBIT = 8
);

   logic            tx_start;
   logic [DBIT-1:0] data_in;
   logic            tx_ready;
   logic            tx_done_tick;

   modport master (
      output tx_start,
      output data_in,
      input  tx_ready,
      input  tx_done_tick
   );

   modport slave (
      input  tx_start,
      input  data_in,
      output tx_ready,
      output tx_done_tick
   );

endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmit engine: shift register, oversample/bit counters, frame FSM
// and the registered serial line.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after
// the MSB (sense chosen by PARITY_ODD). Without it the frame is
// start + DBIT data bits + stop and PARITY_ODD is ignored.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   s_tick     in   16x baud oversample tick
//   load       in   copy load_data into the shift register and start a frame
//   load_data  in   DBIT-wide byte to send
//   idle       out  FSM is in IDLE and can take a load
//   tx         out  registered serial line, idles high
//   done_tick  out  registered 1-cycle pulse at the end of the stop bit
module uart_tx_fsm
   import uart_pkg::*;
#(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            s_tick,
   input  logic            load,
   input  logic [DBIT-1:0] load_data,
   output logic            idle,
   output logic            tx,
   output logic            done_tick
);

   // The tick counter must reach both the 16-tick bit period and the stop
   // length; with the default 16-tick stop bit it is 4 bits wide.
   localparam int SCNT_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
   localparam int NCNT_W = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [SCNT_W-1:0] BIT_LAST  = SCNT_W'(OVERSAMPLE - 1);
   localparam logic [SCNT_W-1:0] STOP_LAST = SCNT_W'(SB_TICK - 1);
   localparam logic [NCNT_W-1:0] NCNT_LAST = NCNT_W'(DBIT - 1);

   uart_state_e       state_q, state_d;
   logic [SCNT_W-1:0] s_cnt_q, s_cnt_d;
   logic [NCNT_W-1:0] n_cnt_q, n_cnt_d;
   logic [DBIT-1:0]   shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              done_q, done_d;

`ifdef UART_TX_PARITY_EN
   logic              parity_q, parity_d;
`else
   localparam int unused_parity_odd = PARITY_ODD;
`endif

   // Next-state logic. The line value is derived from the current state, so
   // the registered line lags each state or bit transition by one clock.
   // Counters only move on s_tick; IDLE ignores ticks and leaves on load.
   always_comb begin
      state_d  = state_q;
      s_cnt_d  = s_cnt_q;
      n_cnt_d  = n_cnt_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (load) begin
               state_d  = START;
               s_cnt_d  = '0;
               n_cnt_d  = '0;
               shift_d  = load_data;
`ifdef UART_TX_PARITY_EN
               parity_d = (^load_data) ^ (PARITY_ODD != 0);
`endif
            end
         end

         START: begin
            tx_d = 1'b0;
            if (s_tick) begin
               if (s_cnt_q == BIT_LAST) begin
                  state_d = DATA;
                  s_cnt_d = '0;
                  n_cnt_d = '0;
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end

         DATA: begin
            tx_d = shift_q[0];
            if (s_tick) begin
               if (s_cnt_q == BIT_LAST) begin
                  s_cnt_d = '0;
                  shift_d = shift_q >> 1;
                  if (n_cnt_q == NCNT_LAST) begin
`ifdef UART_TX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     n_cnt_d = n_cnt_q + 1'b1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_d = parity_q;
            if (s_tick) begin
               if (s_cnt_q == BIT_LAST) begin
                  state_d = STOP;
                  s_cnt_d = '0;
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end
`endif

         STOP: begin
            tx_d = 1'b1;
            if (s_tick) begin
               if (s_cnt_q == STOP_LAST) begin
                  state_d = IDLE;
                  s_cnt_d = '0;
                  done_d  = 1'b1;
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
            s_cnt_d = '0;
            tx_d    = 1'b1;
         end
      endcase
   end

   // State, datapath and output registers. Reset abandons any frame and
   // forces the line high straight away.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         s_cnt_q  <= '0;
         n_cnt_q  <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         s_cnt_q  <= s_cnt_d;
         n_cnt_q  <= n_cnt_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign idle      = (state_q == IDLE);
   assign tx        = tx_q;
   assign done_tick = done_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter top level. Return path of the UART/ALU datapath: takes
// result bytes from the command/ALU side and serialises them to the host.
// A one-byte holding register lets the next byte queue while a frame is on
// the line; the frame engine lives in uart_tx_fsm.
//
// Optional feature: define UART_TX_PARITY_EN to add a parity bit
// (even when PARITY_ODD=0, odd when PARITY_ODD=1).
//
// Parameters: DBIT (data bits, LSB first), SB_TICK (ticks in the stop bit),
// PARITY_ODD (parity sense, used only with UART_TX_PARITY_EN).
//
// Ports:
//   i_clk      in    system clock
//   i_reset_n  in    asynchronous active-low reset
//   i_s_tick   in    16x baud oversample tick from the shared baud generator
//   tx_if      slave byte handshake (start/data in, ready/done out);
//                    the interface DBIT must match this module's DBIT
//   o_tx       out   serial line, idles high, registered
module uart_tx
   import uart_pkg::*;
#(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic     i_clk,
   input  logic     i_reset_n,
   input  logic     i_s_tick,
   uart_tx_if.slave tx_if,
   output logic     o_tx
);

   logic            hold_full_q, hold_full_d;
   logic [DBIT-1:0] hold_data_q, hold_data_d;
   logic            fsm_idle;
   logic            load;

   // A byte moves to the shift register as soon as the engine is idle;
   // no tick is needed, so a queued byte starts the clock after a done pulse.
   assign load = fsm_idle & hold_full_q;

   // Holding register: accept only while empty (a start while full is
   // silently dropped), and free it on the cycle the byte is loaded.
   // Accept and load never coincide since one needs empty, the other full.
   always_comb begin
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      if (load) begin
         hold_full_d = 1'b0;
      end else if (tx_if.tx_start && !hold_full_q) begin
         hold_full_d = 1'b1;
         hold_data_d = tx_if.data_in;
      end
   end

   // Holding register flops.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         hold_full_q <= 1'b0;
         hold_data_q <= '0;
      end else begin
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
      end
   end

   assign tx_if.tx_ready = ~hold_full_q;

   uart_tx_fsm #(
      .DBIT       (DBIT),
      .SB_TICK    (SB_TICK),
      .PARITY_ODD (PARITY_ODD)
   ) u_fsm (
      .clk       (i_clk),
      .rst_n     (i_reset_n),
      .s_tick    (i_s_tick),
      .load      (load),
      .load_data (hold_data_q),
      .idle      (fsm_idle),
      .tx        (o_tx),
      .done_tick (tx_if.tx_done_tick)
   );

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with DBIT=8, SB_TICK=16, PARITY_ODD=0.
// Builds with or without UART_TX_PARITY_EN; parity expectations follow it.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int FRAME_LEN = 175;
`else
   localparam int FRAME_LEN = 159;
`endif

   logic clk;
   logic reset_n;
   logic s_tick;
   logic tx;
   int   tick_div;
   int   cyc = 0;
   int   done_count = 0;
   int   checks = 0;
   int   errors = 0;
   int   frame_fall_cyc = 0;

   uart_tx_if #(.DBIT(8)) bus ();

   uart_tx #(
      .DBIT       (8),
      .SB_TICK    (16),
      .PARITY_ODD (0)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_s_tick  (s_tick),
      .tx_if     (bus),
      .o_tx      (tx)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // cycle counter used to time line edges and done pulses
   always @(posedge clk) cyc <= cyc + 1;

   // running count of done pulses
   always @(negedge clk) begin
      if (bus.tx_done_tick === 1'b1) done_count <= done_count + 1;
   end

   // baud tick: every clock when tick_div=1, else every tick_div-th clock
   initial begin
      int phase;
      phase  = 0;
      s_tick = 1'b1;
      forever begin
         @(negedge clk);
         phase  = (phase + 1) % tick_div;
         s_tick = (phase == 0);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // one-cycle start pulse with a byte
   task automatic applyStimulus(input logic [7:0] data);
      @(negedge clk);
      bus.tx_start = 1'b1;
      bus.data_in  = data;
      @(negedge clk);
      bus.tx_start = 1'b0;
   endtask

   task automatic waitLevel(input logic level, input int limit, output int at_cyc, output bit ok);
      ok     = 1'b0;
      at_cyc = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (tx === level) begin
            ok     = 1'b1;
            at_cyc = cyc;
            break;
         end
      end
   endtask

   // waits for a start bit then checks every bit mid-period, the stop bit,
   // the done pulse and (at full tick rate) the frame length
   task automatic checkFrame(input string tag, input logic [7:0] data, input int bp);
      int f;
      bit ok;
      waitLevel(1'b0, 3000, f, ok);
      checkOutput({tag, " start seen"}, 32'(ok), 32'd1);
      if (!ok) return;
      frame_fall_cyc = f;
      repeat (bp / 2) @(negedge clk);
      checkOutput({tag, " start bit"}, 32'(tx), 32'd0);
      for (int i = 0; i < 8; i++) begin
         repeat (bp) @(negedge clk);
         checkOutput($sformatf("%s bit%0d", tag, i), 32'(tx), 32'(data[i]));
      end
`ifdef UART_TX_PARITY_EN
      repeat (bp) @(negedge clk);
      checkOutput({tag, " parity"}, 32'(tx), 32'(^data));
`endif
      repeat (bp) @(negedge clk);
      checkOutput({tag, " stop bit"}, 32'(tx), 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 2 * bp; i++) begin
         @(negedge clk);
         if (bus.tx_done_tick === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput({tag, " done pulse"}, 32'(ok), 32'd1);
      if (ok && bp == 16) checkOutput({tag, " frame length"}, 32'(cyc - f), 32'(FRAME_LEN));
   endtask

   initial begin
      int  base;
      int  done1;
      int  a;
      int  b;
      bit  ok;
      bit  saw_low;

      tick_div     = 1;
      reset_n      = 1'b0;
      bus.tx_start = 1'b0;
      bus.data_in  = 8'h00;

      // power-on reset
      repeat (3) @(negedge clk);
      checkOutput("por tx", 32'(tx), 32'd1);
      checkOutput("por ready", 32'(bus.tx_ready), 32'd1);
      checkOutput("por done", 32'(bus.tx_done_tick), 32'd0);
      reset_n = 1'b1;

      // reset asserted mid-idle
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("idle rst tx", 32'(tx), 32'd1);
      checkOutput("idle rst ready", 32'(bus.tx_ready), 32'd1);
      checkOutput("idle rst done", 32'(bus.tx_done_tick), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // single byte 0xA5
      $display("[TB] single frame 0xA5");
      base = done_count;
      applyStimulus(8'hA5);
      checkOutput("a5 ready after accept", 32'(bus.tx_ready), 32'd0);
      @(negedge clk);
      checkOutput("a5 ready after load", 32'(bus.tx_ready), 32'd1);
      checkFrame("a5", 8'hA5, 16);
      repeat (20) @(negedge clk);
      checkOutput("a5 done count", 32'(done_count - base), 32'd1);

      // back-to-back 0x0F then 0xF0, with 0x55 dropped while full
      $display("[TB] back-to-back 0x0F, 0xF0, dropped 0x55");
      base = done_count;
      applyStimulus(8'h0F);
      fork
         checkFrame("0f", 8'h0F, 16);
         begin
            repeat (40) @(negedge clk);
            applyStimulus(8'hF0);
            checkOutput("queued ready", 32'(bus.tx_ready), 32'd0);
            applyStimulus(8'h55);
            checkOutput("dropped ready", 32'(bus.tx_ready), 32'd0);
         end
      join
      done1 = cyc;
      checkOutput("ready at done", 32'(bus.tx_ready), 32'd0);
      @(negedge clk);
      checkOutput("ready after load", 32'(bus.tx_ready), 32'd1);
      checkFrame("f0", 8'hF0, 16);
      checkOutput("b2b gap", 32'(frame_fall_cyc - done1), 32'd2);
      saw_low = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) saw_low = 1'b1;
      end
      checkOutput("no third frame", 32'(saw_low), 32'd0);
      checkOutput("b2b done count", 32'(done_count - base), 32'd2);

      // reset during DATA bit 3
      $display("[TB] reset mid-frame");
      base = done_count;
      applyStimulus(8'hA5);
      waitLevel(1'b0, 100, a, ok);
      checkOutput("rst frame started", 32'(ok), 32'd1);
      repeat (69) @(negedge clk);
      checkOutput("rst bit3 before", 32'(tx), 32'd0);
      reset_n = 1'b0;
      #1;
      checkOutput("rst tx", 32'(tx), 32'd1);
      checkOutput("rst ready", 32'(bus.tx_ready), 32'd1);
      checkOutput("rst done", 32'(bus.tx_done_tick), 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (200) @(negedge clk);
      checkOutput("rst no done", 32'(done_count - base), 32'd0);
      checkOutput("rst line idle", 32'(tx), 32'd1);
      applyStimulus(8'h3C);
      checkFrame("3c", 8'h3C, 16);

`ifdef UART_TX_PARITY_EN
      // parity 1 case at full tick rate
      applyStimulus(8'h07);
      checkFrame("07", 8'h07, 16);
`endif

      // tick every 4th clock: 64-clock bit period
      $display("[TB] slow tick");
      repeat (5) @(negedge clk);
      tick_div = 4;
      applyStimulus(8'hA5);
      fork
         checkFrame("slow a5", 8'hA5, 64);
         begin
            waitLevel(1'b0, 3000, a, ok);
            if (ok) waitLevel(1'b1, 200, a, ok);
            if (ok) waitLevel(1'b0, 200, a, ok);
            if (ok) waitLevel(1'b1, 200, b, ok);
            checkOutput("slow edges seen", 32'(ok), 32'd1);
            if (ok) checkOutput("slow bit period", 32'(b - a), 32'd64);
         end
      join

      repeat (10) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
